// File: rtl/reg_bank_scheduler_pkg.sv
// Shared definitions for the register-bank load scheduler: FSM states,
// source selectors and the index of each universal data register.
package reg_bank_scheduler_pkg;

   localparam int ADDR_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   typedef enum logic {
      SRC_RTC = 1'b0,
      SRC_CNT = 1'b1
   } src_e;

   localparam logic [ADDR_W-1:0] REG_SEG      = 4'd0;
   localparam logic [ADDR_W-1:0] REG_MIN      = 4'd1;
   localparam logic [ADDR_W-1:0] REG_HORA     = 4'd2;
   localparam logic [ADDR_W-1:0] REG_DIA      = 4'd3;
   localparam logic [ADDR_W-1:0] REG_MES      = 4'd4;
   localparam logic [ADDR_W-1:0] REG_ANIO     = 4'd5;
   localparam logic [ADDR_W-1:0] REG_TMR_SEG  = 4'd6;
   localparam logic [ADDR_W-1:0] REG_TMR_MIN  = 4'd7;
   localparam logic [ADDR_W-1:0] REG_TMR_HORA = 4'd8;

endpackage

// File: rtl/reg_bank_scheduler_if.sv
// Request/ack bundle between the two load engines and the scheduler,
// plus the hold/select controls the scheduler drives into the bank.
interface reg_bank_scheduler_if
   import reg_bank_scheduler_pkg::*;
#(
   parameter int NUM_REGS = 9
);
   logic                rtc_req;
   logic [ADDR_W-1:0]   rtc_addr;
   logic                cnt_req;
   logic [ADDR_W-1:0]   cnt_addr;
   logic                edit_mode;
   logic [NUM_REGS-1:0] hold;
   logic                chip_select;
   logic                rtc_ack;
   logic                cnt_ack;
   logic                addr_err;
   logic                busy;

   modport slave (
      input  rtc_req, rtc_addr, cnt_req, cnt_addr, edit_mode,
      output hold, chip_select, rtc_ack, cnt_ack, addr_err, busy
   );

   modport master (
      output rtc_req, rtc_addr, cnt_req, cnt_addr, edit_mode,
      input  hold, chip_select, rtc_ack, cnt_ack, addr_err, busy
   );
endinterface

// File: rtl/reg_bank_scheduler_arbiter.sv
// Picks the winner between RTC and counter engines: counter has strict
// priority in edit mode, otherwise round-robin on conflicts.
module rb_arbiter
   import reg_bank_scheduler_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic rtc_req_i,
   input  logic cnt_req_i,
   input  logic edit_mode_i,
   input  logic accept_i,
   output logic valid_o,
   output src_e grant_o
);
   // Resets to counter so that the very first conflict goes to the RTC.
   src_e last_grant_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= SRC_CNT;
      end else if (accept_i) begin
         last_grant_q <= grant_o;
      end
   end

   always_comb begin
      valid_o = 1'b0;
      grant_o = SRC_RTC;
      if (edit_mode_i) begin
         valid_o = cnt_req_i;
         grant_o = SRC_CNT;
      end else if (rtc_req_i && cnt_req_i) begin
         valid_o = 1'b1;
         if (last_grant_q == SRC_CNT) begin
            grant_o = SRC_RTC;
         end else begin
            grant_o = SRC_CNT;
         end
      end else if (rtc_req_i) begin
         valid_o = 1'b1;
         grant_o = SRC_RTC;
      end else if (cnt_req_i) begin
         valid_o = 1'b1;
         grant_o = SRC_CNT;
      end
   end
endmodule

// File: rtl/reg_bank_scheduler.sv
// Three-state load scheduler: captures the winning request in IDLE, drops one
// hold bit for a single cycle in LOAD, then acknowledges the winner in ACK.
module reg_bank_scheduler
   import reg_bank_scheduler_pkg::*;
#(
   parameter int NUM_REGS = 9
)(
   input  logic                 clk,
   input  logic                 reset,
   reg_bank_scheduler_if.slave  bus
);
   state_e            state_q, state_d;
   src_e              grant_q, grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              arb_valid;
   src_e              arb_grant;
   logic              accept;
   logic [NUM_REGS-1:0] hold_w;

   rb_arbiter u_arbiter (
      .clk         (clk),
      .reset       (reset),
      .rtc_req_i   (bus.rtc_req),
      .cnt_req_i   (bus.cnt_req),
      .edit_mode_i (bus.edit_mode),
      .accept_i    (accept),
      .valid_o     (arb_valid),
      .grant_o     (arb_grant)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= SRC_RTC;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               accept  = 1'b1;
               grant_d = arb_grant;
               state_d = ST_LOAD;
               if (arb_grant == SRC_CNT) begin
                  addr_d = bus.cnt_addr;
               end else begin
                  addr_d = bus.rtc_addr;
               end
            end
         end
         ST_LOAD: state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Out-of-range addresses match no bit, so the whole bank stays on hold.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hold
      assign hold_w[gi] = !((state_q == ST_LOAD) && (32'(addr_q) == 32'(gi)));
   end

   assign bus.hold        = hold_w;
   assign bus.chip_select = grant_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.rtc_ack     = (state_q == ST_ACK) && (grant_q == SRC_RTC);
   assign bus.cnt_ack     = (state_q == ST_ACK) && (grant_q == SRC_CNT);
   assign bus.addr_err    = (state_q == ST_ACK) && (32'(addr_q) >= 32'(NUM_REGS));

endmodule

// File: tb/tb_reg_bank_scheduler.sv
// Directed bench for reg_bank_scheduler: fixed-latency transactions,
// arbitration, out-of-range addresses and reset mid-transaction.
module tb_reg_bank_scheduler;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   reg_bank_scheduler_if #(.NUM_REGS(9)) bus ();

   reg_bank_scheduler #(.NUM_REGS(9)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [8:0] hold, input logic cs,
                           input logic rack, input logic cack, input logic aerr, input logic bsy);
      chk({tag, ".hold"},  32'(bus.hold),        32'(hold));
      chk({tag, ".cs"},    32'(bus.chip_select), 32'(cs));
      chk({tag, ".rack"},  32'(bus.rtc_ack),     32'(rack));
      chk({tag, ".cack"},  32'(bus.cnt_ack),     32'(cack));
      chk({tag, ".aerr"},  32'(bus.addr_err),    32'(aerr));
      chk({tag, ".busy"},  32'(bus.busy),        32'(bsy));
      $display("step %-12s hold=%03h cs=%0b rack=%0b cack=%0b aerr=%0b busy=%0b", tag,
               bus.hold, bus.chip_select, bus.rtc_ack, bus.cnt_ack, bus.addr_err, bus.busy);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.rtc_req = 1'b0;
      bus.rtc_addr = 4'd0;
      bus.cnt_req = 1'b0;
      bus.cnt_addr = 4'd0;
      bus.edit_mode = 1'b0;
      step();
      step();
      chk_outs("reset", 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step();

      // Single RTC load of register 2
      bus.rtc_req = 1'b1; bus.rtc_addr = 4'd2;
      step(); chk_outs("rtc2.load", 9'h1FB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(); chk_outs("rtc2.ack",  9'h1FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      bus.rtc_req = 1'b0;
      step(); chk_outs("rtc2.idle", 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Round-robin after a fresh reset: RTC, CNT, RTC
      reset = 1'b1; step(); reset = 1'b0; step();
      bus.rtc_req = 1'b1; bus.rtc_addr = 4'd1;
      bus.cnt_req = 1'b1; bus.cnt_addr = 4'd3;
      step(); chk_outs("rr1.load", 9'h1FD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(); chk_outs("rr1.ack",  9'h1FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(); chk_outs("rr1.idle", 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); chk_outs("rr2.load", 9'h1F7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(); chk_outs("rr2.ack",  9'h1FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(); chk_outs("rr2.idle", 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); chk_outs("rr3.load", 9'h1FD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(); chk_outs("rr3.ack",  9'h1FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      bus.rtc_req = 1'b0; bus.cnt_req = 1'b0;
      step(); chk_outs("rr3.idle", 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Edit mode: counter wins, RTC waits until edit mode ends
      bus.edit_mode = 1'b1;
      bus.rtc_req = 1'b1; bus.rtc_addr = 4'd2;
      bus.cnt_req = 1'b1; bus.cnt_addr = 4'd7;
      step(); chk_outs("edit.load", 9'h17F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(); chk_outs("edit.ack",  9'h1FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      bus.cnt_req = 1'b0;
      step(); chk_outs("edit.idle", 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); chk_outs("edit.wait", 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.edit_mode = 1'b0;
      step(); chk_outs("edit.rload", 9'h1FB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(); chk_outs("edit.rack",  9'h1FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      bus.rtc_req = 1'b0;
      step(); chk_outs("edit.ridle", 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Out-of-range counter address
      bus.cnt_req = 1'b1; bus.cnt_addr = 4'd12;
      step(); chk_outs("oor.load", 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(); chk_outs("oor.ack",  9'h1FF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      bus.cnt_req = 1'b0;
      step(); chk_outs("oor.idle", 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset during LOAD abandons the transaction
      bus.rtc_req = 1'b1; bus.rtc_addr = 4'd4;
      step(); chk_outs("rst.load", 9'h1EF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      reset = 1'b1; bus.rtc_req = 1'b0;
      #1; chk_outs("rst.async", 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); chk_outs("rst.held", 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step(); chk_outs("rst.rel1", 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); chk_outs("rst.rel2", 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Address captured in IDLE; request dropped after grant still completes
      bus.cnt_req = 1'b1; bus.cnt_addr = 4'd0;
      step(); chk_outs("cap.load", 9'h1FE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      bus.cnt_addr = 4'd5; bus.cnt_req = 1'b0;
      step(); chk_outs("cap.ack",  9'h1FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(); chk_outs("cap.idle", 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); chk_outs("cap.none", 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_bank_scheduler.md
REG_BANK_SCHEDULER -- requirements
Module: reg_bank_scheduler

Interface
REQ-001 Parameter SHALL be: NUM_REGS, default 9, number of universal data registers in the bank (seg, min, hora, dia, mes, anio, timer seg/min/hora).
REQ-002 Port SHALL be: clk  input  1  system clock, single clock domain.
REQ-003 Port SHALL be: reset  input  1  system reset, asynchronous, active-high.
REQ-004 Port SHALL be: rtc_req  input  1  RTC read engine requests a register load from RTC data.
REQ-005 Port SHALL be: rtc_addr  input  4  target register index for rtc_req.
REQ-006 Port SHALL be: cnt_req  input  1  counter/edit engine requests a register load from counter data.
REQ-007 Port SHALL be: cnt_addr  input  4  target register index for cnt_req.
REQ-008 Port SHALL be: edit_mode  input  1  user edit active; counter requester gets strict priority.
REQ-009 Port SHALL be: hold  output  NUM_REGS  per-register hold; bit low = register loads this cycle.
REQ-010 Port SHALL be: chip_select  output  1  bank source select; 0 = RTC data, 1 = counter data.
REQ-011 Port SHALL be: rtc_ack  output  1  one-cycle completion pulse to RTC engine.
REQ-012 Port SHALL be: cnt_ack  output  1  one-cycle completion pulse to counter engine.
REQ-013 Port SHALL be: addr_err  output  1  one-cycle pulse, coincident with ack, when granted address >= NUM_REGS.
REQ-014 Port SHALL be: busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM SHALL have states IDLE, LOAD, ACK; IDLE->LOAD on any eligible request, LOAD->ACK unconditionally, ACK->IDLE unconditionally.
REQ-016 In IDLE the block SHALL sample requests, register winner (grant) and its address; no hold bit low in IDLE.
REQ-017 In LOAD, chip_select SHALL equal grant and hold[addr] SHALL be 0 for exactly one cycle, all other bits 1.
REQ-018 In ACK, the winner's ack SHALL pulse high for exactly one cycle; latency request-seen-in-IDLE (cycle N) -> ack at cycle N+2.
REQ-019 Address >= NUM_REGS SHALL keep all hold bits 1 in LOAD and pulse addr_err with ack.
REQ-020 edit_mode=1: cnt_req SHALL win; rtc_req SHALL stay pending, not acked, until edit_mode=0.
REQ-021 edit_mode=0, single request: that requester SHALL be granted.
REQ-022 edit_mode=0, both requesting: round-robin; grant SHALL go to requester not granted last (last_grant register).
REQ-023 Requesters SHALL hold req/addr stable until ack; addr SHALL be captured in IDLE, so later changes SHALL NOT affect the transaction.
REQ-024 Request deasserted after grant SHALL NOT abort; transaction completes and acks.
REQ-025 Request still high in IDLE after ack SHALL be treated as a new transaction (back-to-back period 3 cycles).
REQ-026 chip_select SHALL retain last granted value outside LOAD.

Reset
REQ-027 Reset SHALL force state IDLE, hold all 1s, chip_select 0, rtc_ack/cnt_ack/addr_err/busy 0, last_grant = counter (first conflict goes to RTC).
REQ-028 Reset asserted in LOAD or ACK SHALL abandon the transaction: no ack, no load after reset release.

Structure
REQ-029 Shared package SHALL hold state encodings (IDLE/LOAD/ACK), source constants SRC_RTC=0/SRC_CNT=1, and register index constants for the nine registers.
REQ-030 Arbitration (priority + round-robin) SHALL be one sub-module, rb_arbiter; FSM and hold decode stay in reg_bank_scheduler.

Verification
REQ-031 rtc_req=1, rtc_addr=2, edit_mode=0 at cycle N -> cycle N+1 hold=9'b1_1111_1011, chip_select=0; N+2 rtc_ack=1; N+3 busy=0.
REQ-032 After reset, rtc_req=cnt_req=1 held, edit_mode=0 -> grants alternate RTC, CNT, RTC, each ack 3 cycles apart.
REQ-033 edit_mode=1, rtc_req=1 and cnt_req=1, cnt_addr=7 -> hold[7]=0 with chip_select=1, cnt_ack only; rtc_ack 0 while edit_mode=1.
REQ-034 cnt_req=1, cnt_addr=12 -> hold stays all 1s, cnt_ack and addr_err pulse together at N+2.
REQ-035 rtc_req=1, addr=4, reset asserted during LOAD -> hold all 1s immediately, no rtc_ack, IDLE after release.
REQ-036 cnt_req=1, addr=0, cnt_addr changed to 5 and req dropped at N+1 -> hold[0] loads, cnt_ack at N+2, no further transaction.
